// File: rtl/s2p_lanes_pkg.sv
// Shared types and constants for the multi-lane serial-to-parallel deserializer.
package s2p_lanes_pkg;

    typedef enum logic [1:0] {
        MODO_HOLD = 2'b00,
        MODO_FREE = 2'b01,
        MODO_SYNC = 2'b10,
        MODO_CLR  = 2'b11
    } modo_e;

    typedef enum logic {
        DIR_MSB_FIRST = 1'b0,
        DIR_LSB_FIRST = 1'b1
    } dir_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hBC;

    // Bit-counter width; a 1-bit counter is kept even for degenerate widths.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/s2p_lane.sv
// One lane: WIDTH-bit shift register with direction-selectable insertion.
module s2p_lane
    import s2p_lanes_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             dir,
    input  logic             din,
    output logic [WIDTH-1:0] post_c
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Value the register would hold if this edge shifts.
    always_comb begin
        post_c = {sr_q[WIDTH-2:0], din};
        if (dir == DIR_LSB_FIRST) begin
            post_c = {din, sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (shift_en) begin
            sr_d = post_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/s2p_lanes.sv
// Multi-lane deserializer: word framing counter, sync search on lane 0,
// and a VALID/RDY output register with sticky overflow.
module s2p_lanes
    import s2p_lanes_pkg::*;
#(
    parameter int unsigned      LANES = 4,
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC  = WIDTH'(SYNC_DEFAULT)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   ENB,
    input  logic [LANES-1:0]       S_IN,
    input  logic [1:0]             MODO,
    input  logic                   DIR,
    input  logic                   RDY,
    output logic [LANES*WIDTH-1:0] Q,
    output logic                   VALID,
    output logic                   LOCKED,
    output logic                   OVF
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned QW = LANES * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [QW-1:0] post_c;
    logic          clr_c;
    logic          chg_c;
    logic          shift_c;
    logic          count_c;
    logic          done_c;
    logic          match_c;

    logic [CW-1:0] cnt_q,       cnt_d;
    logic [1:0]    modo_prev_q, modo_prev_d;
    logic [QW-1:0] q_q,         q_d;
    logic          valid_q,     valid_d;
    logic          locked_q,    locked_d;
    logic          ovf_q,       ovf_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        s2p_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (CLK),
            .rst_n    (reset),
            .shift_en (shift_c),
            .clr      (clr_c),
            .dir      (DIR),
            .din      (S_IN[i]),
            .post_c   (post_c[i*WIDTH +: WIDTH])
        );
    end

    // A mode-change edge never shifts; counting only happens once framed.
    always_comb begin
        clr_c   = (MODO == MODO_CLR);
        chg_c   = (MODO != modo_prev_q);
        shift_c = ENB && !chg_c && ((MODO == MODO_FREE) || (MODO == MODO_SYNC));
        count_c = shift_c && ((MODO == MODO_FREE) || locked_q);
        done_c  = count_c && (cnt_q == LAST);
        match_c = shift_c && (MODO == MODO_SYNC) && !locked_q
                  && (post_c[WIDTH-1:0] == SYNC);
    end

    always_comb begin
        cnt_d       = cnt_q;
        modo_prev_d = MODO;
        q_d         = q_q;
        valid_d     = valid_q;
        locked_d    = locked_q;
        ovf_d       = ovf_q;

        if (clr_c) begin
            cnt_d    = '0;
            q_d      = '0;
            valid_d  = 1'b0;
            locked_d = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (chg_c) begin
                cnt_d    = '0;
                locked_d = 1'b0;
            end else if (done_c) begin
                cnt_d = '0;
            end else if (count_c) begin
                cnt_d = cnt_q + CW'(1);
            end else if (match_c) begin
                cnt_d    = '0;
                locked_d = 1'b1;
            end

            // A full output register with no taker drops the new word.
            if (done_c) begin
                if (!valid_q || RDY) begin
                    q_d     = post_c;
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (valid_q && RDY) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            modo_prev_q <= '0;
            q_q         <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            modo_prev_q <= modo_prev_d;
            q_q         <= q_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            ovf_q       <= ovf_d;
        end
    end

    assign Q      = q_q;
    assign VALID  = valid_q;
    assign LOCKED = locked_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_s2p_lanes.sv
// Bench for s2p_lanes: vector table, directed corner sequences, and
// randomized traffic against a bit-history reference model.
module tb_s2p_lanes;

    localparam int unsigned LANES = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned QW    = LANES * WIDTH;
    localparam logic [WIDTH-1:0] SYNC = 8'hBC;

    logic             CLK = 1'b0;
    logic             reset;
    logic             ENB;
    logic [LANES-1:0] S_IN;
    logic [1:0]       MODO;
    logic             DIR;
    logic             RDY;
    logic [QW-1:0]    Q;
    logic             VALID;
    logic             LOCKED;
    logic             OVF;

    int n_tests = 0;
    int n_fail  = 0;

    s2p_lanes #(.LANES(LANES), .WIDTH(WIDTH), .SYNC(SYNC)) dut (
        .CLK    (CLK),
        .reset  (reset),
        .ENB    (ENB),
        .S_IN   (S_IN),
        .MODO   (MODO),
        .DIR    (DIR),
        .RDY    (RDY),
        .Q      (Q),
        .VALID  (VALID),
        .LOCKED (LOCKED),
        .OVF    (OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic             enb;
        logic [LANES-1:0] s_in;
        logic [1:0]       modo;
        logic             dir;
        logic             rdy;
        logic [QW-1:0]    q;
        logic             valid;
    } vec_t;

    vec_t vecs [10];

    // Reference model state: recent input bits per edge, word fill level.
    logic [LANES-1:0] hist [$];
    int               m_nbits;
    logic             m_locked;
    logic             m_valid;
    logic             m_ovf;
    logic [QW-1:0]    m_q;
    logic [1:0]       m_prev;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [QW-1:0] eq, input logic ev,
                           input logic el, input logic eo);
        chk({name, ".Q"},      64'(Q),      64'(eq));
        chk({name, ".VALID"},  64'(VALID),  64'(ev));
        chk({name, ".LOCKED"}, 64'(LOCKED), 64'(el));
        chk({name, ".OVF"},    64'(OVF),    64'(eo));
    endtask

    // Drive bits [from, to) of every lane word in the current DIR order.
    task automatic send_bits(input logic [QW-1:0] w, input int from, input int to,
                             input int stall_at, input int stall_len);
        for (int j = from; j < to; j++) begin
            if (j == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    ENB  = 1'b0;
                    S_IN = LANES'($urandom);
                    tick();
                end
            end
            ENB = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                S_IN[i] = DIR ? w[i*WIDTH + j] : w[i*WIDTH + WIDTH - 1 - j];
            end
            tick();
        end
    endtask

    // Lane word built from the last WIDTH bits received on that lane.
    function automatic logic [WIDTH-1:0] lane_val(input int l, input logic d);
        logic [WIDTH-1:0] v;
        int n;
        v = '0;
        n = hist.size();
        for (int k = 0; k < WIDTH; k++) begin
            if (k < n) begin
                if (d) v[WIDTH-1-k] = hist[n-1-k][l];
                else   v[k]         = hist[n-1-k][l];
            end
        end
        return v;
    endfunction

    task automatic model_step();
        logic done;
        done = 1'b0;
        if (MODO == 2'b11) begin
            hist.delete();
            m_nbits  = 0;
            m_locked = 1'b0;
            m_valid  = 1'b0;
            m_ovf    = 1'b0;
            m_q      = '0;
        end else begin
            if (MODO != m_prev) begin
                m_nbits  = 0;
                m_locked = 1'b0;
            end else if (ENB && (MODO == 2'b01 || MODO == 2'b10)) begin
                hist.push_back(S_IN);
                if (hist.size() > WIDTH) void'(hist.pop_front());
                if (MODO == 2'b01 || m_locked) begin
                    m_nbits++;
                    if (m_nbits == WIDTH) begin
                        done    = 1'b1;
                        m_nbits = 0;
                    end
                end else if (lane_val(0, DIR) == SYNC) begin
                    m_locked = 1'b1;
                    m_nbits  = 0;
                end
            end
            if (done) begin
                if (!m_valid || RDY) begin
                    for (int l = 0; l < LANES; l++) m_q[l*WIDTH +: WIDTH] = lane_val(l, DIR);
                    m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && RDY) begin
                m_valid = 1'b0;
            end
        end
        m_prev = MODO;
    endtask

    initial begin
        logic [QW-1:0]    w0;
        logic [10:0]      pre;
        logic [WIDTH-1:0] sync_v;
        logic [1:0]       base;
        logic             shifting;
        int               sidx;
        int               len;
        int               r;

        reset = 1'b0;
        ENB   = 1'b0;
        S_IN  = '0;
        MODO  = 2'b00;
        DIR   = 1'b0;
        RDY   = 1'b0;
        #12;
        chk_all("reset", '0, 1'b0, 1'b0, 1'b0);
        #10 reset = 1'b1;

        // Free-run MSB-first vector table.
        w0 = 32'hF00F3CA5;
        vecs[0] = '{enb: 1'b1, s_in: '0, modo: 2'b01, dir: 1'b0, rdy: 1'b1, q: '0, valid: 1'b0};
        for (int j = 0; j < WIDTH; j++) begin
            vecs[j+1].enb  = 1'b1;
            vecs[j+1].modo = 2'b01;
            vecs[j+1].dir  = 1'b0;
            vecs[j+1].rdy  = 1'b1;
            for (int i = 0; i < LANES; i++) vecs[j+1].s_in[i] = w0[i*WIDTH + WIDTH - 1 - j];
            vecs[j+1].q     = (j == WIDTH - 1) ? w0 : '0;
            vecs[j+1].valid = (j == WIDTH - 1);
        end
        vecs[9] = '{enb: 1'b0, s_in: '0, modo: 2'b01, dir: 1'b0, rdy: 1'b1, q: w0, valid: 1'b0};
        for (int v = 0; v < 10; v++) begin
            ENB  = vecs[v].enb;
            S_IN = vecs[v].s_in;
            MODO = vecs[v].modo;
            DIR  = vecs[v].dir;
            RDY  = vecs[v].rdy;
            tick();
            chk_all($sformatf("vec%0d", v), vecs[v].q, vecs[v].valid, 1'b0, 1'b0);
        end

        // LSB-first word.
        DIR = 1'b1;
        send_bits(32'h563412A5, 0, WIDTH, -1, 0);
        chk_all("lsb", 32'h563412A5, 1'b1, 1'b0, 1'b0);

        // Sync search: 101 then BC on lane 0, then word 55.
        DIR  = 1'b0;
        MODO = 2'b10;
        ENB  = 1'b1;
        S_IN = '0;
        tick();
        chk_all("sync_enter", 32'h563412A5, 1'b0, 1'b0, 1'b0);
        pre = 11'b101_10111100;
        for (int k = 0; k < 11; k++) begin
            S_IN = LANES'(pre[10-k]);
            tick();
            chk($sformatf("sync_bit%0d.LOCKED", k), 64'(LOCKED), 64'(k == 10));
        end
        chk("sync_lock.Q", 64'(Q), 64'(32'h563412A5));
        send_bits(32'h00000055, 0, WIDTH - 1, -1, 0);
        chk("sync_pre.VALID", 64'(VALID), 64'(0));
        send_bits(32'h00000055, WIDTH - 1, WIDTH, -1, 0);
        chk_all("sync_word", 32'h00000055, 1'b1, 1'b1, 1'b0);

        // Overflow while locked.
        RDY = 1'b1;
        ENB = 1'b0;
        tick();
        chk("ovf_drain.VALID", 64'(VALID), 64'(0));
        RDY = 1'b0;
        send_bits(32'h11223344, 0, WIDTH, -1, 0);
        chk_all("ovf_w1", 32'h11223344, 1'b1, 1'b1, 1'b0);
        send_bits(32'h99887766, 0, WIDTH, -1, 0);
        chk_all("ovf_w2", 32'h11223344, 1'b1, 1'b1, 1'b1);
        RDY = 1'b1;
        ENB = 1'b0;
        tick();
        chk_all("ovf_take", 32'h11223344, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset between edges.
        #2 reset = 1'b0;
        #1;
        chk_all("async_reset", '0, 1'b0, 1'b0, 1'b0);
        #3 reset = 1'b1;

        // MODO=11 clears Q and OVF.
        MODO = 2'b01;
        ENB  = 1'b1;
        RDY  = 1'b0;
        tick();
        send_bits(32'hCAFEF00D, 0, WIDTH, -1, 0);
        send_bits(32'h01234567, 0, WIDTH, -1, 0);
        chk_all("clr_pre", 32'hCAFEF00D, 1'b1, 1'b0, 1'b1);
        MODO = 2'b11;
        tick();
        chk_all("clr", '0, 1'b0, 1'b0, 1'b0);

        // ENB stall inside a word.
        MODO = 2'b01;
        RDY  = 1'b1;
        tick();
        send_bits(32'hE1965AC3, 0, WIDTH, 3, 5);
        chk_all("stall", 32'hE1965AC3, 1'b1, 1'b0, 1'b0);

        // Mode change mid-word restarts framing.
        send_bits(32'hFFFFFFFF, 0, 3, -1, 0);
        MODO = 2'b00;
        tick();
        MODO = 2'b01;
        tick();
        send_bits(32'h78563412, 0, WIDTH - 1, -1, 0);
        chk_all("reframe_pre", 32'hE1965AC3, 1'b0, 1'b0, 1'b0);
        send_bits(32'h78563412, WIDTH - 1, WIDTH, -1, 0);
        chk_all("reframe", 32'h78563412, 1'b1, 1'b0, 1'b0);

        // Randomized segments against the reference model.
        sync_v = SYNC;
        m_prev = MODO;
        for (int seg = 0; seg < 40; seg++) begin
            DIR  = 1'($urandom);
            r    = $urandom_range(0, 4);
            base = (r < 2) ? 2'b01 : ((r < 4) ? 2'b10 : 2'b00);
            MODO = 2'b11;
            ENB  = 1'($urandom);
            RDY  = 1'($urandom);
            S_IN = LANES'($urandom);
            model_step();
            tick();
            chk_all($sformatf("rnd%0d_clr", seg), m_q, m_valid, m_locked, m_ovf);
            sidx = 0;
            len  = $urandom_range(30, 80);
            for (int e = 0; e < len; e++) begin
                MODO = ($urandom_range(0, 29) == 0) ? 2'b00 : base;
                ENB  = ($urandom_range(0, 9) < 8);
                RDY  = ($urandom_range(0, 9) < 7);
                S_IN = LANES'($urandom);
                if (MODO != m_prev) sidx = 0;
                shifting = ENB && (MODO == m_prev) && (MODO == 2'b01 || MODO == 2'b10);
                if (MODO == 2'b10 && shifting && sidx < WIDTH) begin
                    S_IN[0] = DIR ? sync_v[sidx] : sync_v[WIDTH - 1 - sidx];
                    sidx++;
                end
                model_step();
                tick();
                chk_all($sformatf("rnd%0d_%0d", seg, e), m_q, m_valid, m_locked, m_ovf);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
